uart_rx_fifo: RTL and testbench

//  UART receiver peripheral for the j1soc: the receiving end of the serial line driven on uart_rx.

---
 rtl/uart_rx_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver peripheral for the j1soc. It deserialises 8N1 frames from
//   uart_rx_i, buffers the received bytes in a circular FIFO and exposes them
//   through a two-register read-only window. An interrupt is raised while
//   bytes are waiting.
//
// Ports
//   sys_clk_i    in   1   system clock, rising edge
//   sys_rst_n_i  in   1   asynchronous reset, active-low
//   uart_rx_i    in   1   serial input, idle high, asynchronous to sys_clk_i
//   cs_i         in   1   peripheral select
//   rd_i         in   1   read strobe, qualified by cs_i
//   addr_i       in   1   0 = DATA, 1 = STATUS
//   dout_o       out  16  read data, registered
//   irq_o        out  1   high while the FIFO is non-empty
//
// Read handshake: a read is the single cycle in which cs_i & rd_i is high.
// dout_o carries the response from the following cycle on and holds it until
// the next read. There is no back-pressure, so a read is accepted every cycle.
//
// Registers
//   DATA   (addr 0): {8'h00, head byte}, pops the head; 16'h0000 when empty.
//   STATUS (addr 1): {12'h000, overrun, frame_err, full, ~empty}; the read
//                    clears overrun and frame_err (a same-cycle set wins).

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 16
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        uart_rx_i,
    input  logic        cs_i,
    input  logic        rd_i,
    input  logic        addr_i,
    output logic [15:0] dout_o,
    output logic        irq_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    // Receiver state; state_q is the observable FSM state.
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             sync1_q;
    logic             sync2_q;

    // FIFO and register-window state.
    logic [7:0]       mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      dout_q;
    logic             irq_q;

    logic             empty_w;
    logic             full_w;
    logic             rd_en_w;
    logic             pop_w;
    logic             stat_rd_w;
    logic             push_w;
    logic             ferr_set_w;
    logic             wr_en_w;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx_i;
            sync2_q <= sync1_q;
        end
    end

    // Receive FSM. START samples at mid start bit; every later sample lands
    // one full bit period after the previous one, i.e. near mid-bit.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!sync2_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // A line back high at mid start bit was a glitch.
                        state_q   <= sync2_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        // LSB first: shifting right leaves bit 0 at shift_q[0].
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= sync2_q ? S_IDLE : S_BREAK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Hold here until the line recovers so a long break is not
                    // taken as a stream of new start bits.
                    if (sync2_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stop-bit outcome, valid in the single cycle the stop bit is sampled.
    assign push_w     = (state_q == S_STOP) && (cnt_q == FULL_M1) && sync2_q;
    assign ferr_set_w = (state_q == S_STOP) && (cnt_q == FULL_M1) && !sync2_q;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_w   = (wr_ptr_q == rd_ptr_q);
    assign full_w    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en_w   = cs_i & rd_i;
    assign pop_w     = rd_en_w & ~addr_i & ~empty_w;
    assign stat_rd_w = rd_en_w & addr_i;

    // A full FIFO still accepts the byte when a pop frees a slot this cycle.
    assign wr_en_w   = push_w & (~full_w | pop_w);

    assign wr_ptr_d    = wr_ptr_q + (AW + 1)'(wr_en_w);
    assign rd_ptr_d    = rd_ptr_q + (AW + 1)'(pop_w);
    assign overrun_d   = (overrun_q & ~stat_rd_w) | (push_w & full_w & ~pop_w);
    assign frame_err_d = (frame_err_q & ~stat_rd_w) | ferr_set_w;

    always_ff @(posedge sys_clk_i) begin
        if (wr_en_w) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            dout_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            // Built from next-state pointers so irq tracks a push/pop one cycle later.
            irq_q       <= (wr_ptr_d != rd_ptr_d);
            if (rd_en_w) begin
                if (addr_i) begin
                    dout_q <= {12'h000, overrun_q, frame_err_q, full_w, ~empty_w};
                end else if (empty_w) begin
                    dout_q <= 16'h0000;
                end else begin
                    dout_q <= {8'h00, mem_q[rd_ptr_q[AW-1:0]]};
                end
            end
        end
    end

    assign dout_o = dout_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        cs;
  logic        rd;
  logic        addr;
  logic [15:0] dout;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  // Reference model: byte queue plus sticky flags, updated per whole frame/read.
  logic [7:0] m_q[$];
  logic       m_ovr;
  logic       m_ferr;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEPTH)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rst_n_i(rst_n),
    .uart_rx_i  (rx),
    .cs_i       (cs),
    .rd_i       (rd),
    .addr_i     (addr),
    .dout_o     (dout),
    .irq_o      (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // advance n rising edges, then step 1ns so drives sit away from the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_status();
    return {12'h000, m_ovr, m_ferr, (m_q.size() == DEPTH), (m_q.size() != 0)};
  endfunction

  task automatic check_irq(input string name);
    check(name, {15'b0, irq}, {15'b0, (m_q.size() != 0)});
  endtask

  // driver: one register read; expected response goes to the scoreboard
  task automatic do_read(input logic a);
    logic [15:0] e;
    if (a) begin
      e = model_status();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else if (m_q.size() == 0) begin
      e = 16'h0000;
    end else begin
      e = {8'h00, m_q.pop_front()};
    end
    exp_q.push_back(e);
    cs   = 1'b1;
    rd   = 1'b1;
    addr = a;
    cyc(1);
    cs   = 1'b0;
    rd   = 1'b0;
    addr = 1'b0;
  endtask

  // driver: one 8N1 frame; stop_cycles lets the stop level persist (break)
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_cycles);
    rx = 1'b0;
    cyc(CPB);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      cyc(CPB);
    end
    rx = stop_bit;
    cyc(stop_cycles);
    rx = 1'b1;
    if (stop_bit) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
    cyc(4);
  endtask

  // monitor: every accepted read strobe produces one dout value next cycle
  initial begin
    forever begin
      @(posedge clk);
      if (cs && rd) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read: got 0x%04h expected no read at %0t", dout, $time);
        end else begin
          check("dout", dout, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rx     = 1'b1;
    cs     = 1'b0;
    rd     = 1'b0;
    addr   = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    rst_n  = 1'b0;
    cyc(4);
    check("reset_dout", dout, 16'h0000);
    check_irq("reset_irq");
    rst_n = 1'b1;
    cyc(3);

    // 1: single good frame
    send_frame(8'hAE, 1'b1, CPB);
    check_irq("t1_irq_set");
    do_read(1'b1);
    do_read(1'b0);
    do_read(1'b1);
    cyc(2);
    check_irq("t1_irq_clr");

    // 2: short glitch on the line
    rx = 1'b0;
    cyc(4);
    rx = 1'b1;
    cyc(3 * CPB);
    do_read(1'b1);
    cyc(2);
    check_irq("t2_irq");

    // 3: framing error with break, then a good frame
    send_frame(8'h3C, 1'b0, 3 * CPB);
    send_frame(8'h55, 1'b1, CPB);
    do_read(1'b1);
    do_read(1'b0);
    do_read(1'b1);

    // 4: overflow
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, CPB);
    do_read(1'b1);
    for (int i = 0; i < 5; i++) do_read(1'b0);
    cyc(2);
    check_irq("t4_irq");

    // 5: pop in the same cycle as the push into a full FIFO
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, CPB);
    fork
      send_frame(8'h05, 1'b1, CPB);
      begin
        // stop bit is sampled on the 155th edge after the start-bit drive
        cyc(154);
        do_read(1'b0);
      end
    join
    for (int i = 0; i < 4; i++) do_read(1'b0);
    do_read(1'b1);

    // 6: reset in the middle of a frame
    send_frame(8'h77, 1'b1, CPB);
    do_read(1'b1);
    rx = 1'b0;
    cyc(CPB);
    for (int k = 0; k < 3; k++) begin
      rx = (k == 1) ? 1'b0 : 1'b1;
      cyc(CPB);
    end
    rx = 1'b0;
    cyc(CPB / 2);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_dout", dout, 16'h0000);
    check("t6_rst_irq", {15'b0, irq}, 16'h0000);
    m_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    rx = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    send_frame(8'hA5, 1'b1, CPB);
    check_irq("t6_irq");
    do_read(1'b0);
    do_read(1'b1);

    // randomized frames and reads against the model
    for (int f = 0; f < 14; f++) begin
      logic [7:0] b;
      logic       sb;
      int         nrd;
      b   = 8'($urandom_range(0, 255));
      sb  = ($urandom_range(0, 5) != 0);
      send_frame(b, sb, sb ? CPB : CPB + $urandom_range(0, 2 * CPB));
      check_irq("rand_irq");
      nrd = $urandom_range(0, 3);
      for (int r = 0; r < nrd; r++) begin
        do_read(1'($urandom_range(0, 1)));
        cyc($urandom_range(0, 3));
      end
    end
    for (int i = 0; i < DEPTH + 1; i++) do_read(1'b0);
    do_read(1'b1);
    cyc(3);
    check_irq("final_irq");
    check("exp_q_drained", 16'(exp_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
